// File: rtl/fp_cmp_unit.sv
// ---------------------------------------------------------------------------
// fp_cmp_unit
//
// Purpose
//   Standalone multi-cycle floating-point compare engine that answers one
//   fp_exe enable/ready transaction at a time. Handles feq/flt/fle for single
//   (fmt=0) and double (fmt=1) operands and reports NV for NaN cases or
//   unsupported encodings. The returned ready pulse arrives exactly LAT
//   cycles after the cycle in which enable was sampled.
//
// Optional feature
//   FP_CMP_MINMAX_EN : when defined, op_fmax=1 turns the request into
//                      fmin (rm=0) / fmax (rm=1). When undefined, op_fmax is
//                      ignored and no min/max datapath exists.
//
// Parameters
//   LAT      cycles from enable sample to ready pulse (2..8, default 3)
//
// Ports
//   clock    in   1   rising-edge clock for all state
//   reset    in   1   asynchronous, active-low reset
//   enable   in   1   request strobe, operands sampled while high in IDLE
//   data1    in   64  operand A (single uses [31:0] only)
//   data2    in   64  operand B (same packing as data1)
//   fmt      in   2   0=single, 1=double, 2/3 unsupported
//   rm       in   3   compare: 0=fle 1=flt 2=feq; min/max: 0=fmin 1=fmax
//   op_fmax  in   1   min/max request select (FP_CMP_MINMAX_EN builds only)
//   busy     out  1   high from the cycle after accept through the ready cycle
//   result   out  64  compare bit zero-extended, or selected min/max operand
//   flags    out  5   {NV,DZ,OF,UF,NX}; only NV is ever set
//   ready    out  1   one-cycle pulse, result/flags valid only while high
// ---------------------------------------------------------------------------
module fp_cmp_unit #(
    parameter int LAT = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [63:0] data1,
    input  logic [63:0] data2,
    input  logic [1:0]  fmt,
    input  logic [2:0]  rm,
    input  logic        op_fmax,
    output logic        busy,
    output logic [63:0] result,
    output logic [4:0]  flags,
    output logic        ready
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_UNPACK  = 3'd1;
    localparam logic [2:0] S_COMPARE = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [63:0] CANON_NAN_S = 64'h0000_0000_7FC0_0000;
    localparam logic [63:0] CANON_NAN_D = 64'h7FF8_0000_0000_0000;

    typedef struct packed {
        logic nan;
        logic snan;
        logic zero;
    } class_t;

    logic [2:0]  state;
    logic [2:0]  wait_cnt;
    logic [63:0] a_q;
    logic [63:0] b_q;
    logic [1:0]  fmt_q;
    logic [2:0]  rm_q;
    class_t      cls_a_q;
    class_t      cls_b_q;

    class_t      cls_a_c;
    class_t      cls_b_c;
    class_t      cls_a;
    class_t      cls_b;
    logic        dbl;
    logic        sign_a;
    logic        sign_b;
    logic [62:0] mag_a;
    logic [62:0] mag_b;
    logic        both_zero;
    logic        eq_c;
    logic        lt_c;
    logic        any_nan;
    logic        any_snan;
    logic [63:0] res_c;
    logic        nv_c;

`ifdef FP_CMP_MINMAX_EN
    logic        fmax_q;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic        pick_a;
`else
    logic        unused_op_fmax;
    assign unused_op_fmax = op_fmax;
`endif

    // Classify one operand; sign bit is not needed so only [62:0] is passed.
    // Single precision looks only at the low 31 bits of the magnitude field.
    function automatic class_t classify(input logic [62:0] v, input logic is_dbl);
        class_t c;
        logic   exp_ones;
        logic   frac_nz;
        logic   quiet;
        if (is_dbl) begin
            exp_ones = &v[62:52];
            frac_nz  = |v[51:0];
            quiet    = v[51];
            c.zero   = (v == 63'd0);
        end else begin
            exp_ones = &v[30:23];
            frac_nz  = |v[22:0];
            quiet    = v[22];
            c.zero   = (v[30:0] == 31'd0);
        end
        c.nan  = exp_ones & frac_nz;
        c.snan = exp_ones & frac_nz & ~quiet;
        return c;
    endfunction

    // Unsupported formats fall through the single-precision path; their
    // result is overridden to 0/NV further down, so the choice is harmless.
    assign dbl     = (fmt_q == 2'd1);
    assign sign_a  = dbl ? a_q[63] : a_q[31];
    assign sign_b  = dbl ? b_q[63] : b_q[31];
    assign mag_a   = dbl ? a_q[62:0] : {32'd0, a_q[30:0]};
    assign mag_b   = dbl ? b_q[62:0] : {32'd0, b_q[30:0]};
    assign cls_a_c = classify(a_q[62:0], dbl);
    assign cls_b_c = classify(b_q[62:0], dbl);

    // With LAT=2 there is no separate COMPARE cycle, so the final result is
    // built straight from the live classification in the UNPACK cycle.
    assign cls_a = (LAT == 2) ? cls_a_c : cls_a_q;
    assign cls_b = (LAT == 2) ? cls_b_c : cls_b_q;

    // Sign-magnitude ordering. Signed zeros compare equal; for two negative
    // values the larger magnitude is the smaller number.
    always_comb begin
        both_zero = cls_a.zero & cls_b.zero;
        eq_c      = both_zero | ((sign_a == sign_b) && (mag_a == mag_b));
        lt_c      = 1'b0;
        if (!both_zero) begin
            if (sign_a != sign_b) begin
                lt_c = sign_a;
            end else if (sign_a) begin
                lt_c = (mag_a > mag_b);
            end else begin
                lt_c = (mag_a < mag_b);
            end
        end
    end

    assign any_nan  = cls_a.nan | cls_b.nan;
    assign any_snan = cls_a.snan | cls_b.snan;

`ifdef FP_CMP_MINMAX_EN
    // Min/max operand candidates, single results have a zero upper word.
    // For +0/-0 the sign decides: fmin wants the negative zero, fmax the
    // positive one; otherwise the ordering bit picks the operand.
    assign a_ext = dbl ? a_q : {32'd0, a_q[31:0]};
    assign b_ext = dbl ? b_q : {32'd0, b_q[31:0]};

    always_comb begin
        if (both_zero) begin
            pick_a = (rm_q == 3'd0) ? sign_a : ~sign_a;
        end else begin
            pick_a = (rm_q == 3'd0) ? lt_c : ~lt_c;
        end
    end
`endif

    // Final result/NV selection. Unsupported fmt or rm gives 0 with NV set
    // but still runs the full latency so the requester sees a normal pulse.
    always_comb begin
        res_c = 64'd0;
        nv_c  = 1'b0;
        if (fmt_q[1]) begin
            nv_c = 1'b1;
        end
`ifdef FP_CMP_MINMAX_EN
        else if (fmax_q) begin
            if (rm_q > 3'd1) begin
                nv_c = 1'b1;
            end else begin
                nv_c = any_snan;
                if (cls_a.nan && cls_b.nan) begin
                    res_c = dbl ? CANON_NAN_D : CANON_NAN_S;
                end else if (cls_a.nan) begin
                    res_c = b_ext;
                end else if (cls_b.nan) begin
                    res_c = a_ext;
                end else begin
                    res_c = pick_a ? a_ext : b_ext;
                end
            end
        end
`endif
        else begin
            case (rm_q)
                3'd0: begin
                    nv_c     = any_nan;
                    res_c[0] = ~any_nan & (lt_c | eq_c);
                end
                3'd1: begin
                    nv_c     = any_nan;
                    res_c[0] = ~any_nan & lt_c;
                end
                3'd2: begin
                    nv_c     = any_snan;
                    res_c[0] = ~any_nan & eq_c;
                end
                default: begin
                    nv_c = 1'b1;
                end
            endcase
        end
    end

    // Transaction sequencer. Operands are captured only in IDLE, so enable
    // during any busy cycle (including DONE) is simply dropped. The final
    // result is registered at the end of COMPARE (or UNPACK for LAT=2) and
    // then held through the WAIT cycles and beyond the ready pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            wait_cnt <= 3'd0;
            a_q      <= 64'd0;
            b_q      <= 64'd0;
            fmt_q    <= 2'd0;
            rm_q     <= 3'd0;
            cls_a_q  <= '0;
            cls_b_q  <= '0;
            result   <= 64'd0;
            flags    <= 5'd0;
`ifdef FP_CMP_MINMAX_EN
            fmax_q   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        a_q    <= data1;
                        b_q    <= data2;
                        fmt_q  <= fmt;
                        rm_q   <= rm;
`ifdef FP_CMP_MINMAX_EN
                        fmax_q <= op_fmax;
`endif
                        state  <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    cls_a_q <= cls_a_c;
                    cls_b_q <= cls_b_c;
                    if (LAT == 2) begin
                        result <= res_c;
                        flags  <= {nv_c, 4'b0000};
                        state  <= S_DONE;
                    end else begin
                        state  <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    result <= res_c;
                    flags  <= {nv_c, 4'b0000};
                    if (LAT <= 3) begin
                        state <= S_DONE;
                    end else begin
                        wait_cnt <= 3'(LAT - 4);
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        state <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy  = (state != S_IDLE);
    assign ready = (state == S_DONE);

endmodule

// File: tb/tb_fp_cmp_unit.sv
// ---------------------------------------------------------------------------
// tb_fp_cmp_unit
//
// Directed self-checking bench for fp_cmp_unit with LAT=3. Inputs are driven
// and outputs sampled on the falling clock edge, away from the active edge.
// The min/max vectors are compiled in only when FP_CMP_MINMAX_EN is defined.
// ---------------------------------------------------------------------------
module tb_fp_cmp_unit;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [63:0] data1;
    logic [63:0] data2;
    logic [1:0]  fmt;
    logic [2:0]  rm;
    logic        op_fmax;
    logic        busy;
    logic [63:0] result;
    logic [4:0]  flags;
    logic        ready;

    int checks = 0;
    int errors = 0;

    fp_cmp_unit #(.LAT(3)) dut (
        .clock   (clock),
        .reset   (reset),
        .enable  (enable),
        .data1   (data1),
        .data2   (data2),
        .fmt     (fmt),
        .rm      (rm),
        .op_fmax (op_fmax),
        .busy    (busy),
        .result  (result),
        .flags   (flags),
        .ready   (ready)
    );

    // 10 time-unit clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard stop in case the sequence below ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no end of sequence, required finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison point: counts it and reports tag/observed/expected on a miss
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Issue one request at a falling edge, then follow it to its ready pulse,
    // checking busy, latency, result, flags and that ready drops afterwards.
    task automatic applyStimulus(input string tag, input logic [63:0] a,
                                 input logic [63:0] b, input logic [1:0] f,
                                 input logic [2:0] r, input logic mm,
                                 input logic [63:0] expResult,
                                 input logic [4:0] expFlags);
        int lat;
        lat = 0;
        @(negedge clock);
        enable  = 1'b1;
        data1   = a;
        data2   = b;
        fmt     = f;
        rm      = r;
        op_fmax = mm;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            if (k == 1) begin
                enable = 1'b0;
                checkOutput({tag, " busy"}, {63'd0, busy}, 64'd1);
            end
            if (ready && lat == 0) begin
                lat = k;
                break;
            end
        end
        checkOutput({tag, " latency"}, 64'(lat), 64'd3);
        checkOutput({tag, " result"}, result, expResult);
        checkOutput({tag, " flags"}, {59'd0, flags}, {59'd0, expFlags});
        @(negedge clock);
        checkOutput({tag, " ready pulse"}, {63'd0, ready}, 64'd0);
    endtask

    int pulses;

    initial begin
        reset   = 1'b0;
        enable  = 1'b0;
        data1   = 64'd0;
        data2   = 64'd0;
        fmt     = 2'd0;
        rm      = 3'd0;
        op_fmax = 1'b0;

        // Reset state
        repeat (2) @(negedge clock);
        checkOutput("reset busy",   {63'd0, busy},  64'd0);
        checkOutput("reset ready",  {63'd0, ready}, 64'd0);
        checkOutput("reset result", result,         64'd0);
        checkOutput("reset flags",  {59'd0, flags}, 64'd0);
        reset = 1'b1;
        @(negedge clock);

        // Basic ordering, single precision
        applyStimulus("flt 1<2",     64'h3F800000, 64'h40000000, 2'd0, 3'd1, 1'b0, 64'd1, 5'h00);
        applyStimulus("flt 2<1",     64'h40000000, 64'h3F800000, 2'd0, 3'd1, 1'b0, 64'd0, 5'h00);
        applyStimulus("flt -1<1",    64'hBF800000, 64'h3F800000, 2'd0, 3'd1, 1'b0, 64'd1, 5'h00);
        applyStimulus("flt -2<-1",   64'hC0000000, 64'hBF800000, 2'd0, 3'd1, 1'b0, 64'd1, 5'h00);
        applyStimulus("fle 1<=1",    64'h3F800000, 64'h3F800000, 2'd0, 3'd0, 1'b0, 64'd1, 5'h00);
        applyStimulus("flt 1<inf",   64'h3F800000, 64'h7F800000, 2'd0, 3'd1, 1'b0, 64'd1, 5'h00);
        applyStimulus("feq upper ignored", 64'hFFFFFFFF_3F800000, 64'h00000000_3F800000,
                      2'd0, 3'd2, 1'b0, 64'd1, 5'h00);

        // Double precision and signed zero
        applyStimulus("feq -0==0 d", 64'h8000000000000000, 64'h0, 2'd1, 3'd2, 1'b0, 64'd1, 5'h00);
        applyStimulus("flt -0<0 d",  64'h8000000000000000, 64'h0, 2'd1, 3'd1, 1'b0, 64'd0, 5'h00);
        applyStimulus("flt 1<2 d",   64'h3FF0000000000000, 64'h4000000000000000,
                      2'd1, 3'd1, 1'b0, 64'd1, 5'h00);

        // NaN handling
        applyStimulus("feq snan",    64'h7F800001, 64'h3F800000, 2'd0, 3'd2, 1'b0, 64'd0, 5'h10);
        applyStimulus("fle snan",    64'h7F800001, 64'h3F800000, 2'd0, 3'd0, 1'b0, 64'd0, 5'h10);
        applyStimulus("feq qnan",    64'h7FC00000, 64'h3F800000, 2'd0, 3'd2, 1'b0, 64'd0, 5'h00);
        applyStimulus("flt qnan",    64'h7FC00000, 64'h3F800000, 2'd0, 3'd1, 1'b0, 64'd0, 5'h10);
        applyStimulus("feq snan d",  64'h7FF0000000000001, 64'h0, 2'd1, 3'd2, 1'b0, 64'd0, 5'h10);

        // Unsupported encodings
        applyStimulus("rm 3",        64'h3F800000, 64'h3F800000, 2'd0, 3'd3, 1'b0, 64'd0, 5'h10);
        applyStimulus("fmt 2",       64'h3F800000, 64'h3F800000, 2'd2, 3'd2, 1'b0, 64'd0, 5'h10);

        // Back-to-back enable for 6 cycles: requests i=0..5 are feq(i, 4),
        // only i=0 (result 0) and i=4 (result 1) may be accepted.
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            if (ready) begin
                pulses++;
            end
            if (c == 3) begin
                checkOutput("b2b ready@N+3",  {63'd0, ready}, 64'd1);
                checkOutput("b2b result R0",  result,         64'd0);
                checkOutput("b2b busy@N+3",   {63'd0, busy},  64'd1);
            end
            if (c == 4) begin
                checkOutput("b2b busy@N+4",   {63'd0, busy},  64'd0);
            end
            if (c == 7) begin
                checkOutput("b2b ready@N+7",  {63'd0, ready}, 64'd1);
                checkOutput("b2b result R4",  result,         64'd1);
            end
            if (c < 6) begin
                enable = 1'b1;
                data1  = 64'(c);
                data2  = (c == 0) ? 64'd1 : 64'd4;
                fmt    = 2'd0;
                rm     = 3'd2;
            end else begin
                enable = 1'b0;
            end
        end
        checkOutput("b2b pulse count", 64'(pulses), 64'd2);

        // Reset in the middle of a transaction (result currently holds 1)
        @(negedge clock);
        enable = 1'b1;
        data1  = 64'h3F800000;
        data2  = 64'h40000000;
        fmt    = 2'd0;
        rm     = 3'd1;
        @(negedge clock);
        enable = 1'b0;
        reset  = 1'b0;
        #1;
        checkOutput("midrst busy",   {63'd0, busy},  64'd0);
        checkOutput("midrst result", result,         64'd0);
        checkOutput("midrst flags",  {59'd0, flags}, 64'd0);
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            if (ready) begin
                pulses++;
            end
            if (c == 1) begin
                reset = 1'b1;
            end
        end
        checkOutput("midrst no ready", 64'(pulses), 64'd0);
        applyStimulus("after reset", 64'h3F800000, 64'h40000000, 2'd0, 3'd1, 1'b0, 64'd1, 5'h00);

`ifdef FP_CMP_MINMAX_EN
        // Min/max selection
        applyStimulus("fmax qnan",   64'h7FC00000, 64'hBF800000, 2'd0, 3'd1, 1'b1,
                      64'h00000000BF800000, 5'h00);
        applyStimulus("fmin -0,+0",  64'h80000000, 64'h0, 2'd0, 3'd0, 1'b1,
                      64'h0000000080000000, 5'h00);
        applyStimulus("fmax -0,+0",  64'h80000000, 64'h0, 2'd0, 3'd1, 1'b1, 64'h0, 5'h00);
        applyStimulus("fmin 2 nan",  64'h7FC00000, 64'h7F800001, 2'd0, 3'd0, 1'b1,
                      64'h000000007FC00000, 5'h10);
        applyStimulus("fmax d",      64'h3FF0000000000000, 64'h4000000000000000, 2'd1, 3'd1, 1'b1,
                      64'h4000000000000000, 5'h00);
        applyStimulus("minmax rm 2", 64'h3F800000, 64'h3F800000, 2'd0, 3'd2, 1'b1, 64'd0, 5'h10);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
